shift_sequencer: RTL and testbench

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

---
 rtl/shift_sequencer_pkg.sv | 52 +++++
 rtl/shift_sequencer.sv | 101 ++++++++++
 tb/tb_shift_sequencer.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the shift sequencer: default widths, state encoding,
// registered control-word layout and its per-state Moore decode.
package shift_sequencer_pkg;

  localparam int unsigned SIZE_DEF  = 8;
  localparam int unsigned CNT_W_DEF = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    BACK  = 3'd3,
    DONE  = 3'd4
  } state_e;

  typedef struct packed {
    logic set1;
    logic en1;
    logic set2;
    logic en2;
    logic sel_fb;
    logic busy;
    logic done;
    logic err;
  } ctrl_t;

  // Control word held while the FSM sits in state s (err is added separately).
  function automatic ctrl_t decode(state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      LOAD: begin
        c.en1  = 1'b1;
        c.set2 = 1'b1;
        c.busy = 1'b1;
      end
      SHIFT: begin
        c.en2  = 1'b1;
        c.busy = 1'b1;
      end
      BACK: begin
        c.en1    = 1'b1;
        c.sel_fb = 1'b1;
        c.busy   = 1'b1;
      end
      DONE:    c.done = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/shift_sequencer.sv
// Controller for a two-stage shift register pair: loads the operand, then
// ping-pongs stage1 -> stage2 (one bit per pass) cnt times, tracking carry.
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int unsigned SIZE  = SIZE_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] cnt,
  input  logic             rotate,
  input  logic             sh_out,
  output logic             set1,
  output logic             en1,
  output logic             set2,
  output logic             en2,
  output logic             sel_fb,
  output logic             sh_in,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             carry
);

  if (SIZE < 2 || CNT_W < 1) begin : g_bad_param
    $error("shift_sequencer: SIZE must be >= 2 and CNT_W >= 1");
  end

  state_e           state, state_n;
  logic [CNT_W-1:0] remaining, remaining_n;
  logic             rotate_q, rotate_n;
  logic             carry_q, carry_n;
  ctrl_t            ctrl_q, ctrl_n;

  // State register plus registered controls, counter, mode and carry.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= '0;
      rotate_q  <= 1'b0;
      carry_q   <= 1'b0;
      ctrl_q    <= '0;
    end else begin
      state     <= state_n;
      remaining <= remaining_n;
      rotate_q  <= rotate_n;
      carry_q   <= carry_n;
      ctrl_q    <= ctrl_n;
    end
  end

  // Next state; controls are decoded from the next state so they register in step.
  always_comb begin
    state_n     = state;
    remaining_n = remaining;
    rotate_n    = rotate_q;
    carry_n     = carry_q;
    ctrl_n      = '0;
    case (state)
      IDLE: begin
        if (start) begin
          if (cnt != '0) begin
            remaining_n = cnt;
            rotate_n    = rotate;
            state_n     = LOAD;
          end else begin
            ctrl_n.err = 1'b1;
          end
        end
      end
      LOAD:  state_n = SHIFT;
      SHIFT: begin
        carry_n = sh_out;
        state_n = (remaining > CNT_W'(1)) ? BACK : DONE;
      end
      BACK: begin
        remaining_n = remaining - CNT_W'(1);
        state_n     = SHIFT;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    ctrl_n = decode(state_n) | ctrl_n;
  end

  // Shift-in bit must follow the live MSB within the same SHIFT cycle.
  assign sh_in  = (state == SHIFT) & rotate_q & sh_out;

  assign set1   = ctrl_q.set1;
  assign en1    = ctrl_q.en1;
  assign set2   = ctrl_q.set2;
  assign en2    = ctrl_q.en2;
  assign sel_fb = ctrl_q.sel_fb;
  assign busy   = ctrl_q.busy;
  assign done   = ctrl_q.done;
  assign err    = ctrl_q.err;
  assign carry  = carry_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer driving a two-stage shift register datapath with
// a feedback mux; results are compared against an arithmetic shift/rotate model.
module tb_shift_sequencer;

  localparam int unsigned SIZE  = 8;
  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] cnt = '0;
  logic             rotate = 1'b0;
  logic             sh_out;
  logic             set1, en1, set2, en2, sel_fb, sh_in, busy, done, err, carry;
  logic [SIZE-1:0]  operand = '0;
  logic [SIZE-1:0]  r1 = '0;
  logic [SIZE-1:0]  r2 = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_sequencer #(.SIZE(SIZE), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .cnt(cnt), .rotate(rotate),
    .sh_out(sh_out), .set1(set1), .en1(en1), .set2(set2), .en2(en2),
    .sel_fb(sel_fb), .sh_in(sh_in), .busy(busy), .done(done), .err(err),
    .carry(carry)
  );

  // Datapath: stage1 loads operand or stage2; stage2 takes stage1 shifted left.
  assign sh_out = r1[SIZE-1];
  always_ff @(posedge clk) begin
    if (set1)     r1 <= '0;
    else if (en1) r1 <= sel_fb ? r2 : operand;
    if (set2)     r2 <= '0;
    else if (en2) r2 <= {r1[SIZE-2:0], sh_in};
  end

  function automatic logic [SIZE-1:0] ref_result(logic [SIZE-1:0] op, int k, bit rot);
    logic [2*SIZE-1:0] w;
    if (rot) begin
      w = {op, op} << (k % SIZE);
      return w[2*SIZE-1:SIZE];
    end
    if (k >= SIZE) return '0;
    w = {{SIZE{1'b0}}, op} << k;
    return w[SIZE-1:0];
  endfunction

  function automatic logic ref_carry(logic [SIZE-1:0] op, int k, bit rot);
    if (rot) return op[(SIZE - (k % SIZE)) % SIZE];
    if (k > SIZE) return 1'b0;
    return op[SIZE - k];
  endfunction

  // Runs one operation; reports latency, done count, busy anomalies, result and carry.
  task automatic do_op(input logic [SIZE-1:0] op, input int k, input bit rot,
                       input bit inject, output int lat, output int ndone,
                       output int busy_bad, output logic [SIZE-1:0] res,
                       output logic c);
    lat = 0; ndone = 0; busy_bad = 0; res = 'x; c = 1'bx;
    @(negedge clk);
    operand = op; cnt = CNT_W'(k); rotate = rot; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = CNT_W'($urandom); rotate = 1'($urandom);
    for (int cyc = 1; cyc < 45; cyc++) begin
      if (inject && cyc == 2) begin
        start = 1'b1; cnt = CNT_W'($urandom_range(1, 15)); rotate = ~rot;
      end else begin
        start = 1'b0;
      end
      if (done === 1'b1) begin
        ndone++;
        if (busy !== 1'b0) busy_bad++;
        if (lat == 0) begin
          lat = cyc; res = r2; c = carry;
        end
      end else if (lat == 0 && busy !== 1'b1) begin
        busy_bad++;
      end
      if (lat != 0 && cyc >= lat + 3) break;
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({set1, en1, set2, en2, sel_fb, sh_in, busy, done, err, carry} !== 10'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 0",
               {set1, en1, set2, en2, sel_fb, sh_in, busy, done, err, carry});
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [SIZE-1:0] ops [3] = '{8'hB5, 8'hB5, 8'hB5};
    int ks [3] = '{1, 3, 8};
    bit rots [3] = '{1'b0, 1'b1, 1'b0};
    int exp_lat [3] = '{3, 7, 17};
    logic [SIZE-1:0] exp_res [3] = '{8'h6A, 8'hAD, 8'h00};
    int lat, nd, bb;
    logic [SIZE-1:0] res;
    logic c;
    for (int i = 0; i < 3; i++) begin
      do_op(ops[i], ks[i], rots[i], 1'b0, lat, nd, bb, res, c);
      checks++;
      if (lat !== exp_lat[i]) begin
        errors++; $display("FAIL directed%0d_latency: got %0d expected %0d", i, lat, exp_lat[i]);
      end
      checks++;
      if (res !== exp_res[i]) begin
        errors++; $display("FAIL directed%0d_result: got %h expected %h", i, res, exp_res[i]);
      end
      checks++;
      if (c !== 1'b1) begin
        errors++; $display("FAIL directed%0d_carry: got %b expected 1", i, c);
      end
      checks++;
      if (nd !== 1 || bb !== 0) begin
        errors++; $display("FAIL directed%0d_done_busy: dones %0d busy_bad %0d expected 1/0", i, nd, bb);
      end
    end
  endtask

  task automatic test_zero_cnt();
    int extra_err = 0, ndone = 0, bad_ctrl = 0;
    @(negedge clk);
    cnt = '0; rotate = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (err !== 1'b1) begin
      errors++; $display("FAIL zero_cnt_err: got %b expected 1", err);
    end
    for (int i = 0; i < 6; i++) begin
      if ({en1, en2, set1, set2, busy} !== 5'b0) bad_ctrl++;
      if (done !== 1'b0) ndone++;
      if (i > 0 && err !== 1'b0) extra_err++;
      @(negedge clk);
    end
    checks++;
    if (bad_ctrl !== 0 || ndone !== 0 || extra_err !== 0) begin
      errors++;
      $display("FAIL zero_cnt_quiet: ctrl_active %0d dones %0d extra_err %0d expected 0/0/0",
               bad_ctrl, ndone, extra_err);
    end
  endtask

  task automatic test_ignored_start();
    int lat, nd, bb;
    logic [SIZE-1:0] res, op;
    logic c;
    op = SIZE'($urandom);
    do_op(op, 2, 1'b0, 1'b1, lat, nd, bb, res, c);
    checks++;
    if (lat !== 5 || nd !== 1) begin
      errors++; $display("FAIL ignored_start_done: latency %0d dones %0d expected 5/1", lat, nd);
    end
    checks++;
    if (res !== ref_result(op, 2, 1'b0) || c !== ref_carry(op, 2, 1'b0)) begin
      errors++; $display("FAIL ignored_start_result: got %h/%b expected %h/%b",
                         res, c, ref_result(op, 2, 1'b0), ref_carry(op, 2, 1'b0));
    end
  endtask

  task automatic test_reset_mid();
    int lat, nd, bb, k;
    logic [SIZE-1:0] res, op;
    logic c;
    bit rot;
    @(negedge clk);
    operand = 8'hFF; cnt = CNT_W'(4); rotate = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({en1, sel_fb, busy} !== 3'b111) begin
      errors++; $display("FAIL reset_mid_in_back: en1/sel_fb/busy %b expected 111", {en1, sel_fb, busy});
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({set1, en1, set2, en2, sel_fb, sh_in, busy, done, err, carry} !== 10'b0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got %b expected 0",
               {set1, en1, set2, en2, sel_fb, sh_in, busy, done, err, carry});
    end
    rst = 1'b0;
    op = SIZE'($urandom); k = $urandom_range(1, 15); rot = 1'($urandom);
    do_op(op, k, rot, 1'b0, lat, nd, bb, res, c);
    checks++;
    if (lat !== 2 * k + 1 || res !== ref_result(op, k, rot) || c !== ref_carry(op, k, rot)) begin
      errors++; $display("FAIL reset_mid_recover: lat %0d res %h carry %b expected %0d %h %b",
                         lat, res, c, 2 * k + 1, ref_result(op, k, rot), ref_carry(op, k, rot));
    end
  endtask

  task automatic test_random();
    int lat, nd, bb, k;
    logic [SIZE-1:0] res, op;
    logic c;
    bit rot;
    for (int i = 0; i < 24; i++) begin
      op = SIZE'($urandom); k = $urandom_range(1, 15); rot = 1'($urandom);
      do_op(op, k, rot, 1'b0, lat, nd, bb, res, c);
      checks++;
      if (lat !== 2 * k + 1) begin
        errors++; $display("FAIL random%0d_latency: got %0d expected %0d (k=%0d)", i, lat, 2 * k + 1, k);
      end
      checks++;
      if (res !== ref_result(op, k, rot)) begin
        errors++; $display("FAIL random%0d_result: op %h k %0d rot %0d got %h expected %h",
                           i, op, k, rot, res, ref_result(op, k, rot));
      end
      checks++;
      if (c !== ref_carry(op, k, rot)) begin
        errors++; $display("FAIL random%0d_carry: got %b expected %b", i, c, ref_carry(op, k, rot));
      end
      checks++;
      if (nd !== 1 || bb !== 0) begin
        errors++; $display("FAIL random%0d_done_busy: dones %0d busy_bad %0d expected 1/0", i, nd, bb);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_zero_cnt();
    test_ignored_start();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
